// File: rtl/acc_matmul_core.sv
`default_nettype none
// ============================================================================
//  Module      : acc_matmul_core
//  Description : Sequential N x N matrix multiply, C = A x B, with 8-bit
//                operands read through synchronous ports and results written
//                back one element at a time. The optional macro
//                ACC_MATMUL_SAT_EN selects unsigned saturation of each result.
//                Without it the result is truncated to the low DW bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_matmul_core #(
    parameter int N  = 32,
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] a_addr_o,
    input  logic [DW-1:0] a_rdata_i,
    output logic [AW-1:0] b_addr_o,
    input  logic [DW-1:0] b_rdata_i,
    output logic          c_we_o,
    output logic [AW-1:0] c_addr_o,
    output logic [DW-1:0] c_wdata_o
);

    localparam int C_IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int C_ACC_W = 2 * DW + $clog2(N);
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(N - 1);
    localparam logic [AW-1:0]      C_N_A  = AW'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [C_IDX_W-1:0]   r_i;
    logic [C_IDX_W-1:0]   r_j;
    logic [C_IDX_W-1:0]   r_k;
    logic                 r_rd_valid;
    logic [C_ACC_W-1:0]   r_acc;
    logic [2*DW-1:0]      w_prod;
    logic [DW-1:0]        w_result;
    logic [AW-1:0]        w_a_addr;
    logic [AW-1:0]        w_b_addr;
    logic [AW-1:0]        w_c_addr;
    logic                 w_last_elem;

    assign w_prod      = {{DW{1'b0}}, a_rdata_i} * {{DW{1'b0}}, b_rdata_i};
    assign w_a_addr    = AW'(r_i) * C_N_A + AW'(r_k);
    assign w_b_addr    = AW'(r_k) * C_N_A + AW'(r_j);
    assign w_c_addr    = AW'(r_i) * C_N_A + AW'(r_j);
    assign w_last_elem = (r_i == C_LAST) && (r_j == C_LAST);

`ifdef ACC_MATMUL_SAT_EN
    localparam logic [C_ACC_W-1:0] C_SAT_MAX = C_ACC_W'((2 ** DW) - 1);
    assign w_result = (r_acc > C_SAT_MAX) ? {DW{1'b1}} : r_acc[DW-1:0];
`else
    assign w_result = r_acc[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy_o       = (r_state != S_IDLE);
        done_o       = 1'b0;
        a_addr_o     = '0;
        b_addr_o     = '0;
        c_we_o       = 1'b0;
        c_addr_o     = '0;
        c_wdata_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                a_addr_o = w_a_addr;
                b_addr_o = w_b_addr;
                if (r_k == C_LAST) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                c_we_o       = 1'b1;
                c_addr_o     = w_c_addr;
                c_wdata_o    = w_result;
                w_state_next = w_last_elem ? S_DONE : S_RUN;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Read data returns one cycle after each RUN address, so accumulation
    // trails the address sequence by one cycle and finishes in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_rd_valid <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_rd_valid <= (r_state == S_RUN);
            if (r_rd_valid) begin
                r_acc <= r_acc + C_ACC_W'(w_prod);
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_k <= (r_k == C_LAST) ? '0 : r_k + 1'b1;
                end
                S_WRITE: begin
                    r_k   <= '0;
                    r_acc <= '0;
                    if (r_j == C_LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == C_LAST) ? '0 : r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_matmul_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_matmul_core
//  Description : Directed bench for acc_matmul_core with an N=2 and an N=32
//                instance sharing clock and reset; synchronous-read memories
//                model the matrix buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acc_matmul_core;

`ifdef ACC_MATMUL_SAT_EN
    localparam logic [7:0] C_FF_EXP = 8'hFF;
`else
    localparam logic [7:0] C_FF_EXP = 8'h20;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       start2, busy2, done2, we2;
    logic [1:0] aa2, ba2, ca2;
    logic [7:0] ar2, br2, cd2;
    logic       start32, busy32, done32, we32;
    logic [9:0] aa32, ba32, ca32;
    logic [7:0] ar32, br32, cd32;

    logic [7:0] amem2 [4];
    logic [7:0] bmem2 [4];
    logic [7:0] amem32 [1024];
    logic [7:0] bmem32 [1024];

    always @(posedge clk) begin
        ar2  <= amem2[aa2];
        br2  <= bmem2[ba2];
        ar32 <= amem32[aa32];
        br32 <= bmem32[ba32];
    end

    acc_matmul_core #(.N(2), .DW(8), .AW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .a_addr_o(aa2), .a_rdata_i(ar2), .b_addr_o(ba2), .b_rdata_i(br2),
        .c_we_o(we2), .c_addr_o(ca2), .c_wdata_o(cd2)
    );

    acc_matmul_core #(.N(32), .DW(8), .AW(10)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .busy_o(busy32), .done_o(done32),
        .a_addr_o(aa32), .a_rdata_i(ar32), .b_addr_o(ba32), .b_rdata_i(br32),
        .c_we_o(we32), .c_addr_o(ca32), .c_wdata_o(cd32)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Run record: times are the rising edge (counted from the start sample
    // edge) that closes the cycle in which the event was visible.
    int         w_cnt, d_cnt, d_time, busy_low, extra_we, extra_done;
    logic [9:0] w_addr [1024];
    logic [7:0] w_data [1024];
    int         w_time [1024];
    logic [9:0] a_log [10];
    logic [9:0] b_log [10];
    logic       we_log [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        w_cnt = 0; d_cnt = 0; d_time = -1; busy_low = 0; extra_we = 0; extra_done = 0;
        for (int x = 0; x < 1024; x++) begin
            w_addr[x] = 'x; w_data[x] = 'x; w_time[x] = -1;
        end
    endtask

    task automatic run2(input int budget);
        int  m;
        bit  fin;
        clear_rec();
        fin = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        m = 0;
        while (!fin && m < budget) begin
            if (m < 10) begin
                a_log[m] = 10'(aa2); b_log[m] = 10'(ba2); we_log[m] = we2;
            end
            if (we2) begin
                if (w_cnt < 1024) begin
                    w_addr[w_cnt] = 10'(ca2); w_data[w_cnt] = cd2; w_time[w_cnt] = m + 1;
                end
                w_cnt++;
            end
            if (!busy2) busy_low++;
            if (done2) begin d_cnt++; d_time = m + 1; fin = 1'b1; end
            tick();
            m++;
        end
        repeat (4) begin
            if (we2) extra_we++;
            if (done2) extra_done++;
            tick();
        end
    endtask

    task automatic run32(input int budget, input bit pulses);
        int  m;
        bit  fin;
        clear_rec();
        fin = 1'b0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        m = 0;
        while (!fin && m < budget) begin
            if (we32) begin
                if (w_cnt < 1024) begin
                    w_addr[w_cnt] = ca32; w_data[w_cnt] = cd32; w_time[w_cnt] = m + 1;
                end
                w_cnt++;
            end
            if (!busy32) busy_low++;
            if (done32) begin d_cnt++; d_time = m + 1; fin = 1'b1; end
            start32 = pulses && (m == 4 || m == 99);
            tick();
            m++;
        end
        start32 = 1'b0;
        repeat (4) begin
            if (we32) extra_we++;
            if (done32) extra_done++;
            tick();
        end
    endtask

    initial begin
        int m, nd, idle;
        int dt [3];
        logic [7:0] exp_d;

        rst_n = 1'b0; start2 = 1'b0; start32 = 1'b0;
        for (int x = 0; x < 4; x++) begin
            amem2[x] = 8'(x + 1);
            bmem2[x] = 8'(x + 5);
        end
        for (int x = 0; x < 1024; x++) begin
            amem32[x] = ((x / 32) == (x % 32)) ? 8'd1 : 8'd0;
            bmem32[x] = 8'(x % 256);
        end
        tick(); tick();
        check("reset_outs_n2", {busy2, done2, we2, ca2, cd2, aa2, ba2}, 32'd0);
        check("reset_outs_n32", {busy32, done32, we32, ca32, cd32, aa32, ba32}, 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        // N=2 basic run: C = [19,22;43,50]
        run2(100);
        check("n2_write_count", w_cnt, 4);
        check("n2_w0", {w_addr[0], w_data[0]}, {10'd0, 8'd19});
        check("n2_w1", {w_addr[1], w_data[1]}, {10'd1, 8'd22});
        check("n2_w2", {w_addr[2], w_data[2]}, {10'd2, 8'd43});
        check("n2_w3", {w_addr[3], w_data[3]}, {10'd3, 8'd50});
        check("n2_w_times", {8'(w_time[0]), 8'(w_time[1]), 8'(w_time[2]), 8'(w_time[3])},
              {8'd4, 8'd8, 8'd12, 8'd16});
        check("n2_done_time", d_time, 17);
        check("n2_busy_low_during_run", busy_low, 0);
        check("n2_run_k1_addr", {a_log[1], b_log[1]}, {10'd1, 10'd2});
        check("n2_drain_idle_ports", {a_log[2], b_log[2], 9'(we_log[2])}, 32'd0);
        check("n2_elem1_k0_addr", {a_log[4], b_log[4]}, {10'd0, 10'd1});
        check("n2_elem1_k1_addr", {a_log[5], b_log[5]}, {10'd1, 10'd3});
        check("n2_elem2_k1_addr", {a_log[9], b_log[9]}, {10'd3, 10'd2});
        check("n2_after_done", {extra_we, extra_done}, 64'd0);
        check("n2_idle_busy", busy2, 1'b0);

        // N=2 with start held high: back-to-back runs
        start2 = 1'b1; m = 0; nd = 0; idle = 0;
        dt[0] = 0; dt[1] = 0; dt[2] = 0;
        while (nd < 3 && m < 100) begin
            tick();
            m++;
            if (done2) begin dt[nd] = m; nd++; end
            else if (nd == 1 && !busy2) idle++;
        end
        start2 = 1'b0;
        tick(); tick(); tick();
        check("n2_hold_done_count", nd, 3);
        check("n2_hold_period_a", dt[1] - dt[0], 18);
        check("n2_hold_period_b", dt[2] - dt[1], 18);
        check("n2_hold_idle_cycles", idle, 1);

        // N=32 reset during the write of element 10
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        m = 0;
        while (!(we32 && ca32 == 10'd10) && m < 2000) begin
            tick();
            m++;
        end
        check("rst_reached_elem10", {we32, ca32}, {1'b1, 10'd10});
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {busy32, done32, we32, ca32, cd32, aa32, ba32}, 32'd0);
        extra_we = 0; extra_done = 0;
        repeat (3) begin
            tick();
            if (we32) extra_we++;
            if (done32) extra_done++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            if (we32) extra_we++;
            if (done32 || busy32) extra_done++;
        end
        check("rst_no_activity", {extra_we, extra_done}, 64'd0);

        // N=32 identity x ramp: fresh run from element 0
        run32(40000, 1'b0);
        check("id_write_count", w_cnt, 1024);
        for (int x = 0; x < 1024; x++) begin
            check("id_elem", {w_addr[x], w_data[x]}, {10'(x), 8'(x % 256)});
        end
        check("id_first_write_time", w_time[0], 34);
        check("id_done_time", d_time, 34817);
        check("id_done_once", {d_cnt, extra_done, extra_we}, {32'd1, 32'd0, 32'd0});

        // N=32 all 0xFF, extra start pulses during the run
        for (int x = 0; x < 1024; x++) begin
            amem32[x] = 8'hFF;
            bmem32[x] = 8'hFF;
        end
        run32(40000, 1'b1);
        exp_d = C_FF_EXP;
        check("ff_write_count", w_cnt, 1024);
        for (int x = 0; x < 1024; x++) begin
            check("ff_elem", {w_addr[x], w_data[x]}, {10'(x), exp_d});
        end
        check("ff_done_time", d_time, 34817);
        check("ff_busy_low_during_run", busy_low, 0);
        check("ff_done_once", {d_cnt, extra_done, extra_we}, {32'd1, 32'd0, 32'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
